// File: rtl/sa_skew_feeder_if.sv
// sa_skew_feeder_if: job control, operand stream and tile-edge bundle for
// sa_skew_feeder. The CYCLES field exists only when SA_PERF_CNT_EN is defined.
interface sa_skew_feeder_if #(
   parameter int N    = 8,
   parameter int DW   = 16,
   parameter int KMAX = 16
) ();
   localparam int KW = $clog2(KMAX + 1);

   logic            start;
   logic [KW-1:0]   k_len;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] in_x;
   logic [N*DW-1:0] in_w;
   logic [N*DW-1:0] x_edge;
   logic [N*DW-1:0] w_edge;
   logic            sa_en;
   logic            sa_clr;
   logic            busy;
   logic            done;

`ifdef SA_PERF_CNT_EN
   logic [15:0]     cycles;

   modport master (output start, k_len, in_valid, in_x, in_w,
                   input  in_ready, x_edge, w_edge, sa_en, sa_clr, busy, done, cycles);
   modport slave  (input  start, k_len, in_valid, in_x, in_w,
                   output in_ready, x_edge, w_edge, sa_en, sa_clr, busy, done, cycles);
`else
   modport master (output start, k_len, in_valid, in_x, in_w,
                   input  in_ready, x_edge, w_edge, sa_en, sa_clr, busy, done);
   modport slave  (input  start, k_len, in_valid, in_x, in_w,
                   output in_ready, x_edge, w_edge, sa_en, sa_clr, busy, done);
`endif
endinterface

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: buffers K operand beats per lane, then replays them into an
// NxN output-stationary systolic tile with diagonal skew and zero padding.
// Optional job cycle counter (CYCLES) enabled by defining SA_PERF_CNT_EN.
// The interface instance must be built with the same N, DW and KMAX.
module sa_skew_feeder #(
   parameter int N    = 8,
   parameter int DW   = 16,
   parameter int KMAX = 16
) (
   input  logic            clk,
   input  logic            rst,
   sa_skew_feeder_if.slave bus
);
   localparam int KW = $clog2(KMAX + 1);
   localparam int TW = $clog2(KMAX + 2 * N);
   localparam int AW = (KMAX > 1) ? $clog2(KMAX) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [KW-1:0]   k_q_r;
   logic [KW-1:0]   wr_ptr_r;
   logic [TW-1:0]   t_r;
   logic [TW-1:0]   next_t_s;
   logic [TW-1:0]   t_last_s;
   logic            accept_s;
   logic            start_ok_s;
   logic            launch_s;
   logic            last_beat_s;
   logic [DW-1:0]   xbuf_r [N][KMAX];
   logic [DW-1:0]   wbuf_r [N][KMAX];
   logic [N*DW-1:0] x_next_s;
   logic [N*DW-1:0] w_next_s;
   logic [N*DW-1:0] x_edge_r;
   logic [N*DW-1:0] w_edge_r;
   logic            in_ready_r;
   logic            sa_en_r;
   logic            sa_clr_r;
   logic            busy_r;
   logic            done_r;
   int              d_s;

   assign start_ok_s  = bus.start && (bus.k_len != {KW{1'b0}}) && (bus.k_len <= KW'(KMAX));
   assign launch_s    = (state_r == ST_IDLE) && start_ok_s;
   assign accept_s    = bus.in_valid && in_ready_r;
   assign last_beat_s = (wr_ptr_r == (k_q_r - KW'(1)));
   assign t_last_s    = TW'(k_q_r) + TW'(2 * N - 3);

   // Next-state and next RUN counter value.
   always_comb begin
      next_state_s = state_r;
      next_t_s     = {TW{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) next_state_s = ST_LOAD;
            else            next_state_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (accept_s && last_beat_s) next_state_s = ST_RUN;
            else                         next_state_s = ST_LOAD;
         end
         ST_RUN: begin
            if (t_r == t_last_s) begin
               next_state_s = ST_FIN;
            end else begin
               next_state_s = ST_RUN;
               next_t_s     = t_r + TW'(1);
            end
         end
         ST_FIN:  next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Next edge values: lane i carries beat (t-i) inside the window, zero outside.
   // The final beat may be written on the same edge RUN starts, so it is bypassed.
   always_comb begin
      x_next_s = {(N*DW){1'b0}};
      w_next_s = {(N*DW){1'b0}};
      d_s      = 0;
      for (int i = 0; i < N; i++) begin
         d_s = int'(next_t_s) - i;
         if ((next_state_s == ST_RUN) && (d_s >= 0) && (d_s < int'(k_q_r))) begin
            if (accept_s && (d_s == int'(wr_ptr_r))) begin
               x_next_s[i*DW +: DW] = bus.in_x[i*DW +: DW];
               w_next_s[i*DW +: DW] = bus.in_w[i*DW +: DW];
            end else begin
               x_next_s[i*DW +: DW] = xbuf_r[i][AW'(d_s)];
               w_next_s[i*DW +: DW] = wbuf_r[i][AW'(d_s)];
            end
         end else begin
            x_next_s[i*DW +: DW] = {DW{1'b0}};
            w_next_s[i*DW +: DW] = {DW{1'b0}};
         end
      end
   end

   // Lane operand buffers; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         for (int i = 0; i < N; i++) begin
            xbuf_r[i][wr_ptr_r[AW-1:0]] <= bus.in_x[i*DW +: DW];
            wbuf_r[i][wr_ptr_r[AW-1:0]] <= bus.in_w[i*DW +: DW];
         end
      end
   end

   // State, job length, pointers and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         k_q_r      <= {KW{1'b0}};
         wr_ptr_r   <= {KW{1'b0}};
         t_r        <= {TW{1'b0}};
         in_ready_r <= 1'b0;
         sa_en_r    <= 1'b0;
         sa_clr_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         x_edge_r   <= {(N*DW){1'b0}};
         w_edge_r   <= {(N*DW){1'b0}};
      end else begin
         state_r <= next_state_s;
         t_r     <= next_t_s;
         if (launch_s) k_q_r <= bus.k_len;
         else          k_q_r <= k_q_r;
         if (state_r == ST_IDLE) wr_ptr_r <= {KW{1'b0}};
         else if (accept_s)      wr_ptr_r <= wr_ptr_r + KW'(1);
         else                    wr_ptr_r <= wr_ptr_r;
         in_ready_r <= (next_state_s == ST_LOAD);
         sa_clr_r   <= launch_s;
         sa_en_r    <= (next_state_s == ST_RUN);
         busy_r     <= (next_state_s != ST_IDLE);
         done_r     <= (next_state_s == ST_FIN);
         x_edge_r   <= x_next_s;
         w_edge_r   <= w_next_s;
      end
   end

   assign bus.in_ready = in_ready_r;
   assign bus.sa_en    = sa_en_r;
   assign bus.sa_clr   = sa_clr_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.x_edge   = x_edge_r;
   assign bus.w_edge   = w_edge_r;

`ifdef SA_PERF_CNT_EN
   logic [15:0] cycles_r;

   // Job cycle counter: clears on launch, counts non-idle cycles, saturates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                            cycles_r <= 16'd0;
      else if (launch_s)                                   cycles_r <= 16'd0;
      else if ((state_r != ST_IDLE) && (cycles_r != 16'hFFFF)) cycles_r <= cycles_r + 16'd1;
      else                                                 cycles_r <= cycles_r;
   end

   assign bus.cycles = cycles_r;
`endif
endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder: randomized jobs against a reference built from the
// operand matrices (expected skewed edge streams, plus a behavioural tile
// whose sums must equal the directly computed matrix product).
module tb_sa_skew_feeder;
   localparam int N    = 4;
   localparam int DW   = 16;
   localparam int KMAX = 16;
   localparam int KW   = $clog2(KMAX + 1);

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [DW-1:0] xm [N][KMAX];
   logic [DW-1:0] wm [KMAX][N];
   longint        acc [N][N];
   logic [DW-1:0] xr  [N][N];
   logic [DW-1:0] wr  [N][N];

   sa_skew_feeder_if #(.N(N), .DW(DW), .KMAX(KMAX)) bus ();

   sa_skew_feeder #(.N(N), .DW(DW), .KMAX(KMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tile_clear();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc[i][j] = 0;
            xr[i][j]  = '0;
            wr[i][j]  = '0;
         end
   endtask

   // One tile clock: X flows right, W flows down, each PE multiply-accumulates.
   task automatic tile_step(input logic [N*DW-1:0] xe, input logic [N*DW-1:0] we);
      logic [DW-1:0] a, b;
      for (int i = N - 1; i >= 0; i--)
         for (int j = N - 1; j >= 0; j--) begin
            if (j == 0) a = xe[i*DW +: DW];
            else        a = xr[i][j-1];
            if (i == 0) b = we[j*DW +: DW];
            else        b = wr[i-1][j];
            acc[i][j] = acc[i][j] + longint'(a) * longint'(b);
            xr[i][j]  = a;
            wr[i][j]  = b;
         end
   endtask

   // gap_mode: 0 back-to-back, 1 valid pattern 1,0,0,..., 2 random.
   // pat: 0 random operands, 1 X=identity and W=1..N*K.
   task automatic run_job(input int k, input int gap_mode, input int pat,
                          input bit poke, input int abort_t);
      int               cnt, ldc;
      bit               v;
      logic [N*DW-1:0]  ex, ew;
      longint           y;
      for (int kk = 0; kk < KMAX; kk++)
         for (int i = 0; i < N; i++) begin
            if (pat == 1) begin
               xm[i][kk] = (i == kk) ? DW'(1) : DW'(0);
               wm[kk][i] = DW'(kk * N + i + 1);
            end else begin
               xm[i][kk] = DW'($urandom);
               wm[kk][i] = DW'($urandom);
            end
         end
      tile_clear();

      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.k_len    = KW'(k);
      bus.in_valid = 1'b1;
      bus.in_x     = {$urandom, $urandom};
      bus.in_w     = {$urandom, $urandom};
      @(negedge clk);
      check_val("start_cycle_ctl", {bus.sa_en, bus.sa_clr, bus.busy, bus.done, bus.in_ready}, 5'b00000);
      @(posedge clk); #1;
      bus.start = 1'b0;

      cnt = 0;
      ldc = 0;
      while (cnt < k && ldc < 200) begin
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (ldc % 3 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.in_valid = v;
         if (v) begin
            for (int i = 0; i < N; i++) begin
               bus.in_x[i*DW +: DW] = xm[i][cnt];
               bus.in_w[i*DW +: DW] = wm[cnt][i];
            end
         end else begin
            bus.in_x = {$urandom, $urandom};
            bus.in_w = {$urandom, $urandom};
         end
         @(negedge clk);
         check_val("load_ctl", {bus.sa_en, bus.sa_clr, bus.busy, bus.done, bus.in_ready},
                   {1'b0, (ldc == 0), 1'b1, 1'b0, 1'b1});
         @(posedge clk); #1;
         if (v) cnt++;
         ldc++;
      end
      if (cnt < k) check_val("load_timeout", 64'(cnt), 64'(k));
      bus.in_valid = 1'b0;

      for (int t = 0; t < k + 2 * N - 2; t++) begin
         @(negedge clk);
         if (t == abort_t) begin
            rst = 1'b0;
            #1;
            check_val("rst_x_edge", bus.x_edge, 64'd0);
            check_val("rst_w_edge", bus.w_edge, 64'd0);
            check_val("rst_ctl", {bus.sa_en, bus.sa_clr, bus.busy, bus.done, bus.in_ready}, 5'b00000);
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check_val("post_rst_ctl", {bus.sa_en, bus.sa_clr, bus.busy, bus.done, bus.in_ready}, 5'b00000);
            return;
         end
         ex = '0;
         ew = '0;
         for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < k) begin
               ex[i*DW +: DW] = xm[i][t-i];
               ew[i*DW +: DW] = wm[t-i][i];
            end
         end
         check_val("x_edge", bus.x_edge, ex);
         check_val("w_edge", bus.w_edge, ew);
         check_val("run_ctl", {bus.sa_en, bus.sa_clr, bus.busy, bus.done, bus.in_ready}, 5'b10100);
         tile_step(bus.x_edge, bus.w_edge);
         if (poke && t == 2) begin
            bus.start = 1'b1;
            bus.k_len = KW'($urandom_range(1, KMAX));
         end
         if (poke && t == 3) bus.start = 1'b0;
      end

      @(negedge clk);
      check_val("fin_ctl", {bus.sa_en, bus.sa_clr, bus.busy, bus.done, bus.in_ready}, 5'b00110);
      check_val("fin_edges", bus.x_edge | bus.w_edge, 64'd0);
      bus.start = 1'b1;
      bus.k_len = KW'(k);
      @(negedge clk);
      bus.start = 1'b0;
      check_val("after_done_ctl", {bus.sa_en, bus.sa_clr, bus.busy, bus.done, bus.in_ready}, 5'b00000);
`ifdef SA_PERF_CNT_EN
      check_val("cycles", 64'(bus.cycles), 64'(ldc + k + 2 * N - 2 + 1));
`endif
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            y = 0;
            for (int kk = 0; kk < k; kk++) y = y + longint'(xm[i][kk]) * longint'(wm[kk][j]);
            check_val("tile_y", acc[i][j], y);
         end
   endtask

   task automatic illegal_start(input int kl);
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.k_len    = KW'(kl);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_val("illegal_ctl", {bus.sa_en, bus.sa_clr, bus.busy, bus.done, bus.in_ready}, 5'b00000);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.k_len    = '0;
      bus.in_valid = 1'b0;
      bus.in_x     = '0;
      bus.in_w     = '0;
      #13;
      check_val("reset_x_edge", bus.x_edge, 64'd0);
      check_val("reset_w_edge", bus.w_edge, 64'd0);
      check_val("reset_ctl", {bus.sa_en, bus.sa_clr, bus.busy, bus.done, bus.in_ready}, 5'b00000);
`ifdef SA_PERF_CNT_EN
      check_val("reset_cycles", 64'(bus.cycles), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b1;

      run_job(4, 0, 1, 1'b0, -1);          // identity X, sequential W
      illegal_start(0);
      illegal_start(KMAX + 1);
      run_job(3, 1, 0, 1'b0, -1);          // valid gaps
      run_job(6, 0, 0, 1'b0, 5);           // reset during RUN t=5
      run_job(2, 0, 0, 1'b0, -1);
      run_job(4, 0, 0, 1'b1, -1);          // START poked during RUN
      run_job(1, 0, 0, 1'b0, -1);
      run_job(KMAX, 2, 0, 1'b0, -1);
      repeat (5) run_job($urandom_range(1, KMAX), 2, 0, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
